// File: rtl/serial_cmd_loader.sv
// serial_cmd_loader: byte-stream command parser feeding the serial pattern generator.
// Opcodes: 0x01 LOAD_DATA, 0x02 LOAD_FREQ (BYTE_NUM payload bytes, LSB first),
// 0x03 START (1 payload byte, bit0 = mode), 0x04 STOP (no payload).
// Patterns land in staging registers and reach the active outputs only on START.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_rx_data/valid   received byte and its one-cycle strobe
//   o_start, o_stop   one-cycle pulses to the pattern generator
//   o_mode            active mode (0 one-shot, 1 repeat)
//   o_output_pattern  active output pattern
//   o_freq_pattern    active frequency pattern
//   o_busy            high while a command payload is being received
//   o_cmd_done        one-cycle pulse on successful command completion
//   o_cmd_err         one-cycle pulse on error, cause in o_err_code (1 opcode, 2 timeout)
module serial_cmd_loader #(
    parameter int unsigned DATA_BIT       = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_start,
    output logic                o_stop,
    output logic                o_mode,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic                o_busy,
    output logic                o_cmd_done,
    output logic                o_cmd_err,
    output logic [1:0]          o_err_code
);

    localparam int unsigned BYTE_NUM = DATA_BIT / 8;
    localparam int unsigned IDX_W    = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0] OP_LOAD_DATA = 8'h01;
    localparam logic [7:0] OP_LOAD_FREQ = 8'h02;
    localparam logic [7:0] OP_START     = 8'h03;
    localparam logic [7:0] OP_STOP      = 8'h04;

    // Latched opcode only needs its low two bits (1, 2 or 3).
    localparam logic [1:0] OPC_LOAD_DATA = 2'd1;
    localparam logic [1:0] OPC_START     = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BYTE_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic {
        S_CMD     = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BIT-1:0]  asm_q, asm_d;
    logic [DATA_BIT-1:0]  stg_data_q, stg_data_d;
    logic [DATA_BIT-1:0]  stg_freq_q, stg_freq_d;

    logic                 start_d, stop_d, done_d, err_d, busy_d, mode_d;
    logic [1:0]           err_code_d;
    logic [DATA_BIT-1:0]  out_pat_d, freq_pat_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        stg_data_d = stg_data_q;
        stg_freq_d = stg_freq_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = o_err_code;
        mode_d     = o_mode;
        out_pat_d  = o_output_pattern;
        freq_pat_d = o_freq_pattern;

        unique case (state_q)
            S_CMD: begin
                if (i_rx_valid) begin
                    unique case (i_rx_data)
                        OP_LOAD_DATA, OP_LOAD_FREQ, OP_START: begin
                            op_d    = i_rx_data[1:0];
                            idx_d   = '0;
                            cnt_d   = '0;
                            state_d = S_PAYLOAD;
                        end
                        OP_STOP: begin
                            stop_d = 1'b1;
                            done_d = 1'b1;
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OPCODE;
                        end
                    endcase
                end
            end

            S_PAYLOAD: begin
                if (i_rx_valid) begin
                    // An arriving byte always wins over an expiring timeout.
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (op_q == OPC_START) begin
                        out_pat_d  = stg_data_q;
                        freq_pat_d = stg_freq_q;
                        mode_d     = i_rx_data[0];
                        start_d    = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_CMD;
                    end else begin
                        for (int i = 0; i < int'(BYTE_NUM); i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                asm_d[8*i +: 8] = i_rx_data;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            if (op_q == OPC_LOAD_DATA) begin
                                stg_data_d = asm_d;
                            end else begin
                                stg_freq_d = asm_d;
                            end
                            done_d  = 1'b1;
                            state_d = S_CMD;
                        end
                    end
                end else if (cnt_q == CNT_EXPIRE) begin
                    // Abort leaves staging untouched; partial word is dropped.
                    cnt_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_CMD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_CMD;
        endcase

        busy_d = (state_d == S_PAYLOAD);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_CMD;
            op_q             <= '0;
            idx_q            <= '0;
            cnt_q            <= '0;
            asm_q            <= '0;
            stg_data_q       <= '0;
            stg_freq_q       <= '0;
            o_start          <= 1'b0;
            o_stop           <= 1'b0;
            o_mode           <= 1'b0;
            o_output_pattern <= '0;
            o_freq_pattern   <= '0;
            o_busy           <= 1'b0;
            o_cmd_done       <= 1'b0;
            o_cmd_err        <= 1'b0;
            o_err_code       <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            asm_q            <= asm_d;
            stg_data_q       <= stg_data_d;
            stg_freq_q       <= stg_freq_d;
            o_start          <= start_d;
            o_stop           <= stop_d;
            o_mode           <= mode_d;
            o_output_pattern <= out_pat_d;
            o_freq_pattern   <= freq_pat_d;
            o_busy           <= busy_d;
            o_cmd_done       <= done_d;
            o_cmd_err        <= err_d;
            o_err_code       <= err_code_d;
        end
    end

endmodule

// File: doc/serial_cmd_loader.md
Name: serial_cmd_loader

Overview:
- Upstream command front-end for the serial pattern generator: parses a byte stream from the UART receiver and produces that block's i_start, i_stop, i_mode, i_output_pattern and i_freq_pattern.
- Patterns are assembled in staging registers and copied to the active outputs only when a START command executes, so a pattern currently being played is never corrupted by a partial load.
- Reports per-command completion and error pulses.

Parameters:
DATA_BIT, 32, pattern width; must be a multiple of 8; BYTE_NUM = DATA_BIT/8 payload bytes per load.
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between consecutive payload bytes; must be >= 2.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_rx_data  input  8  received byte; valid only when i_rx_valid=1
i_rx_valid  input  1  one-cycle byte strobe from UART RX
o_start  output  1  one-cycle start pulse to the pattern generator
o_stop  output  1  one-cycle stop pulse to the pattern generator
o_mode  output  1  0 = one-shot, 1 = repeat; the active value
o_output_pattern  output  DATA_BIT  active output pattern
o_freq_pattern  output  DATA_BIT  active frequency pattern; 1 = high freq, 0 = low freq
o_busy  output  1  1 while a command payload is being received
o_cmd_done  output  1  one-cycle pulse when a command completes successfully
o_cmd_err  output  1  one-cycle pulse on a command error
o_err_code  output  2  error cause, valid with o_cmd_err: 1 = unknown opcode, 2 = payload timeout; otherwise holds its last value

Behaviour:
- Reset, asynchronous: every output and internal register is 0 and the state is S_CMD. Reset mid-payload discards the partial payload; staging and active patterns are cleared.
- Opcodes:
  - 0x01 LOAD_DATA: BYTE_NUM payload bytes, LSB byte first. Writes staging_data.
  - 0x02 LOAD_FREQ: BYTE_NUM payload bytes, LSB byte first. Writes staging_freq.
  - 0x03 START: 1 payload byte; bit0 = mode, bits[7:1] are ignored.
  - 0x04 STOP: no payload.
- States:
  - S_CMD: idle, waits for i_rx_valid.
    - 0x01, 0x02 or 0x03: latch the opcode, clear the byte index and timeout counter, go to S_PAYLOAD.
    - 0x04: o_stop=1 and o_cmd_done=1 in the next cycle; stay in S_CMD.
    - Any other byte: o_cmd_err=1 and o_err_code=1 in the next cycle; stay in S_CMD.
  - S_PAYLOAD: each accepted byte is shifted into an assembly register at bit position [8*idx+7 : 8*idx], then idx increments and the timeout counter clears.
    - LOAD commands: on the final byte (idx = BYTE_NUM-1), the complete word is copied to the staging register, o_cmd_done pulses in the next cycle, and the FSM returns to S_CMD.
    - START: on the payload byte, on the same clock edge: o_output_pattern <= staging_data, o_freq_pattern <= staging_freq, o_mode <= byte[0], o_start <= 1, o_cmd_done <= 1. The FSM returns to S_CMD. Active data is therefore valid in the same cycle o_start is high.
    - Timeout: with no i_rx_valid, the counter increments each cycle. When the counter reaches TIMEOUT_CYCLES-1, the FSM aborts to S_CMD, pulses o_cmd_err with o_err_code=2, and leaves the staging registers unchanged.
    - A byte arriving in the same cycle the timeout would fire is accepted, and no timeout occurs.
- o_busy = (state == S_PAYLOAD), registered via the state register.
- Latency: one clk from the final byte's i_rx_valid cycle to o_start, o_stop, o_cmd_done or o_cmd_err.
- All pulse outputs deassert after one cycle; o_start and o_stop are never asserted together.
- Active outputs change only on START execution. LOAD commands never alter the active outputs.
- Back-to-back bytes (i_rx_valid high on consecutive cycles) must be accepted with no gaps.
- i_rx_data is ignored when i_rx_valid=0.
- The counter width is sized as clog2(TIMEOUT_CYCLES). No wrap-around occurs because the counter resets on abort.

Test Plan:
- Reset, then a LOAD_DATA sequence 0x01, 0x78, 0x56, 0x34, 0x12 -> o_cmd_done one cycle after the last byte; o_output_pattern stays 0x00000000; o_busy is 1 from the cycle after 0x01 through the last byte.
- Then LOAD_FREQ 0x02, 0xF0, 0x0F, 0xAA, 0x55, then START 0x03, 0x01 -> single o_start pulse with o_output_pattern=0x12345678, o_freq_pattern=0x55AA0FF0, o_mode=1 in that same cycle; o_cmd_done coincident.
- STOP 0x04 -> o_stop=1 for exactly one cycle, one cycle after the byte; active patterns unchanged.
- Unknown byte 0x7E -> o_cmd_err=1 with o_err_code=1 in the next cycle; FSM stays in S_CMD; a following valid command still works.
- TIMEOUT_CYCLES=16: send 0x01, 0xAA, 0xBB, then idle -> o_cmd_err with o_err_code=2 after 16 idle cycles; staging unchanged, verified by a subsequent START outputting the previous pattern. Repeat with the third byte arriving exactly at cycle 15 -> no error.
- Send 0x01 plus 2 bytes, pulse rst_n low mid-payload, then send START 0x03, 0x00 -> o_start with both patterns = 0 and o_mode=0.
